// File: rtl/core_pkg.sv
// Shared branch-unit definitions: funct3 codes, FSM encoding, BHT reset value.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package core_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Redirect bookkeeping: FLUSH covers the one wrong-path slot after a redirect.
  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  // Every BHT entry starts weakly not-taken.
  localparam logic [1:0] BHT_RST = 2'b01;

  // Taken decision from the shared comparator outputs.
  function automatic logic br_taken(input logic [2:0] f3, input logic eq, input logic lt);
    logic res;
    res = 1'b0;
    case (f3)
      F3_BEQ:           res = eq;
      F3_BNE:           res = !eq;
      F3_BLT, F3_BLTU:  res = lt;
      F3_BGE, F3_BGEU:  res = !lt;
      default:          res = 1'b0;
    endcase
    return res;
  endfunction

  // funct3 010 and 011 are not branches.
  function automatic logic br_legal(input logic [2:0] f3);
    return f3[2:1] != 2'b01;
  endfunction

endpackage

// File: rtl/branch_ctrl_if.sv
// Branch-unit bundle between the IF/EX pipeline and branch_ctrl.
// Latency: n/a (wires only).
// Backpressure: stall freezes the consumer; no valid/ready handshake.
interface branch_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             stall;
  logic [31:0]      if_pc;
  logic             if_pred_taken;
  logic             ex_valid;
  logic             ex_is_branch;
  logic [2:0]       ex_funct3;
  logic [31:0]      ex_pc;
  logic             ex_pred_taken;
  logic             BrEq;
  logic             BrLt;
  logic             BrUn;
  logic             redirect;
  logic             redirect_taken;
  logic             if_kill;
  logic             illegal_br;
  logic [CNT_W-1:0] br_count;
  logic [CNT_W-1:0] mispred_count;

  modport master (
    output stall, if_pc, ex_valid, ex_is_branch, ex_funct3, ex_pc, ex_pred_taken, BrEq, BrLt,
    input  if_pred_taken, BrUn, redirect, redirect_taken, if_kill, illegal_br,
           br_count, mispred_count
  );

  modport slave (
    input  stall, if_pc, ex_valid, ex_is_branch, ex_funct3, ex_pc, ex_pred_taken, BrEq, BrLt,
    output if_pred_taken, BrUn, redirect, redirect_taken, if_kill, illegal_br,
           br_count, mispred_count
  );
endinterface

// File: rtl/bht_2bit.sv
// Untagged 2-bit saturating-counter branch history table.
// Latency: read is combinational; an update is visible the cycle after wr_en.
// Backpressure: none; caller gates wr_en (stall handling lives upstream).
module bht_2bit
  import core_pkg::*;
#(
  parameter int IDX_BITS = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IDX_BITS-1:0] rd_idx,
  output logic                rd_pred,
  input  logic                wr_en,
  input  logic [IDX_BITS-1:0] wr_idx,
  input  logic                wr_taken
);
  localparam int N = 1 << IDX_BITS;

  logic [1:0] bht_q [N];
  logic [1:0] bht_d [N];

  // No bypass from the write port: prediction is the stored counter MSB.
  assign rd_pred = bht_q[rd_idx][1];

  // Saturating step of the addressed counter toward the resolved direction.
  always_comb begin
    bht_d = bht_q;
    if (wr_en) begin
      if (wr_taken && (bht_q[wr_idx] != 2'b11)) begin
        bht_d[wr_idx] = bht_q[wr_idx] + 2'd1;
      end else if (!wr_taken && (bht_q[wr_idx] != 2'b00)) begin
        bht_d[wr_idx] = bht_q[wr_idx] - 2'd1;
      end
    end
  end

  // Table storage with asynchronous reset to weakly not-taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) bht_q[i] <= BHT_RST;
    end else begin
      bht_q <= bht_d;
    end
  end

endmodule

// File: rtl/branch_ctrl.sv
// Branch resolve/predict: taken decision, mispredict redirect, IF kill, BHT and perf counters.
// Latency: decision/redirect combinational in EX; if_kill one cycle after redirect.
// Backpressure: stall freezes BHT, counters and FSM and suppresses resolution.
module branch_ctrl
  import core_pkg::*;
#(
  parameter int IDX_BITS = 6,
  parameter int CNT_W    = 32
) (
  input logic         clk,
  input logic         rst,
  branch_ctrl_if.slave bus
);
  state_t               state_q;
  logic [CNT_W-1:0]     br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0]     mp_cnt_q, mp_cnt_d;
  logic [IDX_BITS-1:0]  if_idx, ex_idx;
  logic                 taken, legal, eff_valid, resolve, redirect;
  logic                 unused_pc_bits;

  assign if_idx = bus.if_pc[IDX_BITS+1:2];
  assign ex_idx = bus.ex_pc[IDX_BITS+1:2];
  // No tags: the remaining PC bits play no part in indexing.
  assign unused_pc_bits = ^{bus.if_pc[31:IDX_BITS+2], bus.if_pc[1:0],
                            bus.ex_pc[31:IDX_BITS+2], bus.ex_pc[1:0]};

  // Decision path; rst masks it so a branch sitting in EX cannot redirect during reset.
  assign taken     = br_taken(bus.ex_funct3, bus.BrEq, bus.BrLt);
  assign legal     = br_legal(bus.ex_funct3);
  assign eff_valid = bus.ex_valid & bus.ex_is_branch & (state_q == RUN) & !rst;
  assign resolve   = eff_valid & legal & !bus.stall;
  assign redirect  = resolve & (taken != bus.ex_pred_taken);

  assign bus.BrUn           = bus.ex_funct3[1];
  assign bus.redirect       = redirect;
  assign bus.redirect_taken = taken;
  assign bus.illegal_br     = eff_valid & !legal;
  assign bus.if_kill        = (state_q == FLUSH);
  assign bus.br_count       = br_cnt_q;
  assign bus.mispred_count  = mp_cnt_q;

  bht_2bit #(
    .IDX_BITS (IDX_BITS)
  ) u_bht (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (if_idx),
    .rd_pred  (bus.if_pred_taken),
    .wr_en    (resolve),
    .wr_idx   (ex_idx),
    .wr_taken (taken)
  );

  // Perf counters: count on resolution, stick at all-ones instead of wrapping.
  always_comb begin
    br_cnt_d = br_cnt_q;
    mp_cnt_d = mp_cnt_q;
    if (resolve && (br_cnt_q != '1)) br_cnt_d = br_cnt_q + 1'b1;
    if (redirect && (mp_cnt_q != '1)) mp_cnt_d = mp_cnt_q + 1'b1;
  end

  // Perf counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_cnt_q <= '0;
      mp_cnt_q <= '0;
    end else begin
      br_cnt_q <= br_cnt_d;
      mp_cnt_q <= mp_cnt_d;
    end
  end

  // RUN/FLUSH sequencer: one non-stalled FLUSH cycle absorbs the wrong-path slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
    end else begin
      case (state_q)
        RUN:     if (redirect) state_q <= FLUSH;
        FLUSH:   if (!bus.stall) state_q <= RUN;
        default: state_q <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed bench for branch_ctrl with hand-computed expectations.
// Latency: inputs driven 1ns after posedge, outputs sampled 1ns later.
// Backpressure: stall driven explicitly by the vectors.
module tb_branch_ctrl;
  import core_pkg::*;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_pass;

  branch_ctrl_if #(.CNT_W(32)) bus ();

  branch_ctrl #(
    .IDX_BITS (6),
    .CNT_W    (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic vld, input logic [2:0] f3, input logic [31:0] pc,
                       input logic pred, input logic eq, input logic lt);
    bus.ex_valid      = vld;
    bus.ex_is_branch  = vld;
    bus.ex_funct3     = f3;
    bus.ex_pc         = pc;
    bus.ex_pred_taken = pred;
    bus.BrEq          = eq;
    bus.BrLt          = lt;
    #1;
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rst    = 1'b1;
    bus.stall = 1'b0;
    bus.if_pc = 32'h100;
    drive(1'b0, F3_BEQ, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    #1;

    // Reset state
    check("rst_pred", bus.if_pred_taken, 0);
    check("rst_brcnt", bus.br_count, 0);
    check("rst_mpcnt", bus.mispred_count, 0);
    check("rst_kill", bus.if_kill, 0);
    check("rst_redir", bus.redirect, 0);
    check("rst_ill", bus.illegal_br, 0);

    // BLT taken, predicted not-taken at idx 16
    bus.if_pc = 32'h40;
    drive(1'b1, F3_BLT, 32'h40, 1'b0, 1'b0, 1'b1);
    check("blt_brun", bus.BrUn, 0);
    check("blt_redir", bus.redirect, 1);
    check("blt_rtaken", bus.redirect_taken, 1);
    check("blt_nobypass", bus.if_pred_taken, 0);
    tick();
    // Same branch still in EX is the wrong-path slot and must be ignored
    check("flush_kill", bus.if_kill, 1);
    check("flush_redir", bus.redirect, 0);
    check("blt_brcnt", bus.br_count, 1);
    check("blt_mpcnt", bus.mispred_count, 1);
    check("blt_bht", dut.u_bht.bht_q[16], 2'b10);
    check("blt_pred", bus.if_pred_taken, 1);
    tick();
    check("flush_done", bus.if_kill, 0);
    check("flush_brcnt", bus.br_count, 1);

    // Same index taken twice from reset: 01 -> 10 -> 11
    bus.if_pc = 32'h80;
    drive(1'b1, F3_BEQ, 32'h80, 1'b1, 1'b1, 1'b0);
    check("beq_redir", bus.redirect, 0);
    check("beq_pred0", bus.if_pred_taken, 0);
    tick();
    check("beq_pred1", bus.if_pred_taken, 1);
    check("beq_bht1", dut.u_bht.bht_q[32], 2'b10);
    check("beq_brcnt1", bus.br_count, 2);
    tick();
    check("beq_bht2", dut.u_bht.bht_q[32], 2'b11);
    check("beq_brcnt2", bus.br_count, 3);
    check("beq_mpcnt", bus.mispred_count, 1);

    // BGEU taken, correctly predicted; counter saturates at 11
    drive(1'b1, F3_BGEU, 32'h80, 1'b1, 1'b0, 1'b0);
    check("bgeu_brun", bus.BrUn, 1);
    check("bgeu_redir", bus.redirect, 0);
    tick();
    check("bgeu_brcnt", bus.br_count, 4);
    check("bgeu_mpcnt", bus.mispred_count, 1);
    check("bgeu_bht", dut.u_bht.bht_q[32], 2'b11);

    // Illegal funct3 codes
    drive(1'b1, 3'b010, 32'h80, 1'b0, 1'b1, 1'b0);
    check("ill010", bus.illegal_br, 1);
    check("ill010_redir", bus.redirect, 0);
    tick();
    check("ill_brcnt", bus.br_count, 4);
    check("ill_mpcnt", bus.mispred_count, 1);
    check("ill_bht", dut.u_bht.bht_q[32], 2'b11);
    drive(1'b1, 3'b011, 32'h80, 1'b0, 1'b1, 1'b0);
    check("ill011", bus.illegal_br, 1);
    drive(1'b0, 3'b010, 32'h80, 1'b0, 1'b1, 1'b0);
    check("ill_novalid", bus.illegal_br, 0);

    // Stall in RUN blocks resolution
    bus.stall = 1'b1;
    drive(1'b1, F3_BEQ, 32'h40, 1'b0, 1'b1, 1'b0);
    check("stall_redir", bus.redirect, 0);
    tick();
    check("stall_brcnt", bus.br_count, 4);
    check("stall_bht", dut.u_bht.bht_q[16], 2'b10);
    bus.stall = 1'b0;

    // BNE not taken, predicted taken -> redirect to fall-through
    drive(1'b1, F3_BNE, 32'h80, 1'b1, 1'b1, 1'b0);
    check("bne_redir", bus.redirect, 1);
    check("bne_rtaken", bus.redirect_taken, 0);
    tick();
    check("bne_brcnt", bus.br_count, 5);
    check("bne_mpcnt", bus.mispred_count, 2);
    check("bne_bht", dut.u_bht.bht_q[32], 2'b10);

    // FLUSH held by 3 stall cycles, then one more FLUSH cycle
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stl_kill", bus.if_kill, 1);
      check("stl_redir", bus.redirect, 0);
      tick();
    end
    check("stl_bht", dut.u_bht.bht_q[32], 2'b10);
    check("stl_mpcnt", bus.mispred_count, 2);
    bus.stall = 1'b0;
    #1;
    check("post_kill", bus.if_kill, 1);
    tick();
    check("run_kill", bus.if_kill, 0);
    check("run_brcnt", bus.br_count, 5);

    // Reset asserted during FLUSH with a branch still in EX
    drive(1'b1, F3_BLT, 32'h40, 1'b0, 1'b0, 1'b1);
    tick();
    check("pre_rst_kill", bus.if_kill, 1);
    check("pre_rst_brcnt", bus.br_count, 6);
    check("pre_rst_bht", dut.u_bht.bht_q[16], 2'b11);
    rst = 1'b1;
    #1;
    check("arst_kill", bus.if_kill, 0);
    check("arst_brcnt", bus.br_count, 0);
    check("arst_mpcnt", bus.mispred_count, 0);
    check("arst_redir", bus.redirect, 0);
    check("arst_bht", dut.u_bht.bht_q[16], 2'b01);
    tick();
    rst = 1'b0;
    drive(1'b0, F3_BEQ, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    check("end_kill", bus.if_kill, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
